// File: rtl/fetch_seq_pkg.sv
// Shared sequencer definitions: state encodings, opcodes and the word-count rule.
// The fetch sequencer and the datapath both decode against these values.
package fetch_seq_pkg;

   typedef enum logic [3:0] {
      FETCH_0 = 4'd0,
      FETCH_1 = 4'd1,
      EXEC_0  = 4'd2,
      EXEC_1  = 4'd3,
      STORE_0 = 4'd4,
      HALT    = 4'd5
   } seq_state_t;

   localparam logic [7:0] OP_NOP    = 8'h00;
   localparam logic [7:0] OP_LIMM16 = 8'h01;
   localparam logic [7:0] OP_LIMM32 = 8'h02;
   localparam logic [7:0] OP_LBSET  = 8'h03;
   localparam logic [7:0] OP_END    = 8'hFF;

   // Ops that carry a second word fetched in FETCH_1.
   function automatic logic [1:0] op_words(input logic [7:0] op);
      return (op == OP_LIMM32 || op == OP_LBSET) ? 2'd2 : 2'd1;
   endfunction

endpackage

// File: rtl/fetch_seq_if.sv
// Program-memory read port: request/address out, acknowledge/data back.
interface fetch_seq_if;
   logic [15:0] mem_addr;
   logic        mem_req;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (output mem_addr, mem_req, input mem_ack, mem_rdata);
   modport slave  (input mem_addr, mem_req, output mem_ack, mem_rdata);
endinterface

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: fetches 1- or 2-word ops and steps the datapath phases.
// Build option FETCH_NOP_SKIP_EN: OP_NOP returns straight to FETCH_0 after its fetch.
//
// state   | meaning
// FETCH_0 | request opcode word at pc
// FETCH_1 | request second word of a 2-word op
// EXEC_0  | datapath execute phase 0
// EXEC_1  | datapath execute phase 1
// STORE_0 | write-back; branch target accepted here
// HALT    | OP_END executed, idle until reset
module fetch_seq
   import fetch_seq_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   fetch_seq_if.master mem,
   output logic [31:0] instr0,
   output logic [31:0] instr1,
   output logic [3:0]  current_state,
   input  logic        jmp_we,
   input  logic [15:0] jmp_addr,
   output logic [15:0] pc,
   output logic        halted
);

   seq_state_t  state_q, state_d;
   logic [15:0] pc_q;
   logic [31:0] instr0_q, instr1_q;
   logic        active_q;
   logic        fetch_ok;
   logic [7:0]  op_rd, op_cur;

   // active_q keeps the request low for the first cycle after reset release.
   assign fetch_ok = active_q & mem.mem_ack;
   assign op_rd    = mem.mem_rdata[31:24];
   assign op_cur   = instr0_q[31:24];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FETCH_0;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH_0: begin
            if (fetch_ok) begin
               if (op_words(op_rd) == 2'd2) state_d = FETCH_1;
`ifdef FETCH_NOP_SKIP_EN
               else if (op_rd == OP_NOP)    state_d = FETCH_0;
`endif
               else                         state_d = EXEC_0;
            end
         end
         FETCH_1: if (fetch_ok) state_d = EXEC_0;
         EXEC_0:  state_d = EXEC_1;
         EXEC_1:  state_d = STORE_0;
         STORE_0: state_d = (op_cur == OP_END) ? HALT : FETCH_0;
         HALT:    state_d = HALT;
         default: state_d = FETCH_0;
      endcase
   end

   always_comb begin
      mem.mem_req   = active_q & (state_q == FETCH_0 || state_q == FETCH_1);
      mem.mem_addr  = pc_q;
      halted        = (state_q == HALT);
      current_state = state_q;
      pc            = pc_q;
      instr0        = instr0_q;
      instr1        = instr1_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= RESET_PC;
         instr0_q <= '0;
         instr1_q <= '0;
         active_q <= 1'b0;
      end else begin
         active_q <= 1'b1;
         case (state_q)
            FETCH_0: if (fetch_ok) begin
               instr0_q <= mem.mem_rdata;
               instr1_q <= '0;
               pc_q     <= pc_q + 16'd1;
            end
            FETCH_1: if (fetch_ok) begin
               instr1_q <= mem.mem_rdata;
               pc_q     <= pc_q + 16'd1;
            end
            // A halting op never redirects the pc.
            STORE_0: if (jmp_we && op_cur != OP_END) pc_q <= jmp_addr;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: the bench plays program memory cycle by cycle.
module tb_fetch_seq;
   import fetch_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        jmp_we;
   logic [15:0] jmp_addr;
   logic [31:0] instr0, instr1;
   logic [3:0]  current_state;
   logic [15:0] pc;
   logic        halted;
   int          total = 0;
   int          bad = 0;
   int          cyc;

   fetch_seq_if bus();

   fetch_seq #(.RESET_PC(16'h0000)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mem           (bus),
      .instr0        (instr0),
      .instr1        (instr1),
      .current_state (current_state),
      .jmp_we        (jmp_we),
      .jmp_addr      (jmp_addr),
      .pc            (pc),
      .halted        (halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Entered and left on a falling edge; inputs apply to the next rising edge.
   task automatic step(input logic ack, input logic [31:0] rd);
      bus.mem_ack   = ack;
      bus.mem_rdata = rd;
      @(posedge clk);
      @(negedge clk);
      bus.mem_ack = 1'b0;
      jmp_we      = 1'b0;
   endtask

   function automatic logic [31:0] w(input logic [7:0] op, input logic [23:0] imm);
      return {op, imm};
   endfunction

   task automatic run1(input logic [31:0] word);
      step(1'b1, word);
      step(1'b0, 32'h0);
      step(1'b0, 32'h0);
      step(1'b0, 32'h0);
   endtask

   initial begin
      rst_n = 1'b0; jmp_we = 1'b0; jmp_addr = 16'h0;
      bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
      repeat (2) @(negedge clk);
      chk("rst_state",  32'(current_state), 32'(FETCH_0));
      chk("rst_pc",     32'(pc), 32'h0);
      chk("rst_instr0", instr0, 32'h0);
      chk("rst_instr1", instr1, 32'h0);
      chk("rst_halted", 32'(halted), 32'h0);
      chk("rst_req",    32'(bus.mem_req), 32'h0);

      rst_n = 1'b1;
      chk("req_at_release", 32'(bus.mem_req), 32'h0);
      step(1'b0, 32'h0);
      chk("req_first_rise", 32'(bus.mem_req), 32'h1);
      chk("addr_reset_pc",  32'(bus.mem_addr), 32'h0);

      // single-word op, ack in the request cycle
      step(1'b1, w(OP_LIMM16, 24'h001234));
      chk("limm16_exec0",  32'(current_state), 32'(EXEC_0));
      chk("limm16_pc",     32'(pc), 32'h1);
      chk("limm16_instr0", instr0, 32'h01001234);
      step(1'b0, 32'h0);
      chk("limm16_exec1",  32'(current_state), 32'(EXEC_1));
      step(1'b0, 32'h0);
      chk("limm16_store",  32'(current_state), 32'(STORE_0));
      step(1'b0, 32'h0);
      chk("limm16_back",   32'(current_state), 32'(FETCH_0));
      chk("limm16_naddr",  32'(bus.mem_addr), 32'h1);

      // ack delayed three cycles: request held four cycles
      for (int i = 0; i < 4; i++) begin
         chk("wait_state", 32'(current_state), 32'(FETCH_0));
         chk("wait_req",   32'(bus.mem_req), 32'h1);
         chk("wait_addr",  32'(bus.mem_addr), 32'h1);
         if (i < 3) step(1'b0, 32'hFFFF_FFFF);
      end
      step(1'b1, w(OP_LIMM16, 24'h000002));
      chk("wait_done_pc", 32'(pc), 32'h2);
      step(1'b0, 32'h0); step(1'b0, 32'h0); step(1'b0, 32'h0);
      run1(w(OP_LIMM16, 24'h000003));
      run1(w(OP_LIMM16, 24'h000004));
      chk("at_pc4", 32'(bus.mem_addr), 32'h4);

      // two-word op
      step(1'b1, w(OP_LIMM32, 24'h000004));
      chk("limm32_fetch1", 32'(current_state), 32'(FETCH_1));
      chk("limm32_pc5",    32'(pc), 32'h5);
      chk("limm32_addr5",  32'(bus.mem_addr), 32'h5);
      chk("limm32_i1_clr", instr1, 32'h0);
      chk("limm32_req",    32'(bus.mem_req), 32'h1);
      step(1'b1, 32'hDEADBEEF);
      chk("limm32_exec0",  32'(current_state), 32'(EXEC_0));
      chk("limm32_instr1", instr1, 32'hDEADBEEF);
      chk("limm32_pc6",    32'(pc), 32'h6);
      step(1'b0, 32'h0); step(1'b0, 32'h0);
      chk("limm32_i1_hold", instr1, 32'hDEADBEEF);
      chk("limm32_i0_hold", instr0, 32'h02000004);
      step(1'b0, 32'h0);
      chk("limm32_naddr",  32'(bus.mem_addr), 32'h6);

      // stray acks in EXEC ignored; branch only honoured in STORE_0
      step(1'b1, w(OP_LIMM16, 24'h000006));
      step(1'b1, 32'hBAD0BAD0);
      jmp_we = 1'b1; jmp_addr = 16'h0200;
      step(1'b1, 32'hBAD1BAD1);
      chk("jmp_exec1_ign", 32'(pc), 32'h7);
      chk("stray_ack_ign", instr0, 32'h01000006);
      chk("jmp_store_st",  32'(current_state), 32'(STORE_0));
      jmp_we = 1'b1; jmp_addr = 16'h0100;
      step(1'b0, 32'h0);
      chk("jmp_taken",     32'(bus.mem_addr), 32'h0100);

      // branch to the last word and wrap
      step(1'b1, w(OP_LIMM16, 24'h000100));
      step(1'b0, 32'h0); step(1'b0, 32'h0);
      jmp_we = 1'b1; jmp_addr = 16'hFFFF;
      step(1'b0, 32'h0);
      chk("jmp_ffff",      32'(bus.mem_addr), 32'hFFFF);
      step(1'b1, w(OP_LIMM16, 24'h00FFFF));
      chk("pc_wrap",       32'(pc), 32'h0);
      step(1'b0, 32'h0); step(1'b0, 32'h0); step(1'b0, 32'h0);
      chk("wrap_naddr",    32'(bus.mem_addr), 32'h0);

      // OP_END halts; branch in its STORE_0 and later acks ignored
      step(1'b1, w(OP_END, 24'h0));
      step(1'b0, 32'h0); step(1'b0, 32'h0);
      jmp_we = 1'b1; jmp_addr = 16'h0300;
      step(1'b0, 32'h0);
      chk("halt_state",    32'(current_state), 32'(HALT));
      for (int i = 0; i < 24; i++) begin
         chk("halt_flag", 32'(halted), 32'h1);
         chk("halt_req",  32'(bus.mem_req), 32'h0);
         jmp_we = 1'b1;
         step(1'b1, w(OP_LIMM16, 24'h0));
      end
      chk("halt_hold_st",  32'(current_state), 32'(HALT));

      // reset during FETCH_1 abandons the request
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("halt_cleared",  32'(halted), 32'h0);
      step(1'b0, 32'h0);
      step(1'b1, w(OP_LIMM32, 24'h0));
      chk("mid_fetch1",    32'(current_state), 32'(FETCH_1));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req",   32'(bus.mem_req), 32'h0);
      chk("mid_rst_state", 32'(current_state), 32'(FETCH_0));
      chk("mid_rst_pc",    32'(pc), 32'h0);
      chk("mid_rst_i0",    instr0, 32'h0);
      @(negedge clk);
      step(1'b1, 32'hDEADBEEF);
      rst_n = 1'b1;
      step(1'b1, 32'hDEADBEEF);
      chk("rel_addr",      32'(bus.mem_addr), 32'h0);
      chk("rel_req",       32'(bus.mem_req), 32'h1);
      chk("rel_state",     32'(current_state), 32'(FETCH_0));
      chk("rel_instr1",    instr1, 32'h0);

      // NOP duration depends on the build option
      step(1'b1, w(OP_NOP, 24'h0));
      cyc = 1;
      while (current_state != 4'(FETCH_0) && cyc < 10) begin
         step(1'b0, 32'h0);
         cyc++;
      end
`ifdef FETCH_NOP_SKIP_EN
      chk("nop_cycles",    32'(cyc), 32'd1);
`else
      chk("nop_cycles",    32'(cyc), 32'd4);
`endif
      chk("nop_naddr",     32'(bus.mem_addr), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
